// File: rtl/stepper_step_ctrl_if.sv
// Command handshake bundle for stepper_step_ctrl: valid/ready plus the move parameters.
interface stepper_step_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;
    logic [DIV_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_steps, cmd_dir, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_dir, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_step_ctrl.sv
// Move command stage for the stepper phase sequencer: emits step_en strobes every cmd_period clocks.
// Optional macro STEP_ABORT_EN adds an abort input that ends a running move early.
module stepper_step_ctrl #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef STEP_ABORT_EN
    input  logic               abort,
`endif
    stepper_step_ctrl_if.slave cmd,
    output logic               step_en,
    output logic               dir,
    output logic               busy,
    output logic [CNT_W-1:0]   remaining,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_rem,    w_rem_nxt;
    logic [DIV_W-1:0] r_tick,   w_tick_nxt;
    logic [DIV_W-1:0] r_period, w_period_nxt;
    logic             r_dir,    w_dir_nxt;
    logic             r_step,   w_step_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_busy,   w_busy_nxt;
    logic [DIV_W-1:0] w_p_eff;
    logic             w_abort;

`ifdef STEP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_p_eff = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_tick   <= '0;
            r_period <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_tick   <= w_tick_nxt;
            r_period <= w_period_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // Strobe outputs are computed one cycle ahead so step_en lands exactly on multiples of the period.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_tick_nxt   = r_tick;
        w_period_nxt = r_period;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_busy_nxt   = r_busy;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (cmd.cmd_valid) begin
                    w_dir_nxt    = cmd.cmd_dir;
                    w_period_nxt = w_p_eff;
                    w_rem_nxt    = cmd.cmd_steps;
                    w_tick_nxt   = w_p_eff - DIV_W'(1);
                    w_busy_nxt   = 1'b1;
                    if (cmd.cmd_steps == '0) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_step_nxt  = (w_p_eff == DIV_W'(1));
                    end
                end
            end
            S_RUN: begin
                if (r_step) begin
                    // A strobe in flight is always counted, even when an abort arrives with it.
                    w_rem_nxt  = r_rem - CNT_W'(1);
                    w_tick_nxt = r_period - DIV_W'(1);
                    if ((r_rem == CNT_W'(1)) || w_abort) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_step_nxt = (r_period == DIV_W'(1));
                    end
                end else begin
                    w_tick_nxt = r_tick - DIV_W'(1);
                    if (w_abort) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_step_nxt = (r_tick == DIV_W'(1));
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign step_en       = r_step;
    assign dir           = r_dir;
    assign busy          = r_busy;
    assign remaining     = r_rem;
    assign done          = r_done;

endmodule
